video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1024, active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 160, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 768, active lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 3, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 29, vertical back porch in lines.
REQ-009 The block SHALL have parameter SYNC_POL, default 0, sync active level: 0 = active-low, 1 = active-high.
REQ-010 The block SHALL have port I_pxl_clk, input, 1, 65 MHz pixel clock from the pixel PLL.
REQ-011 The block SHALL have port I_rst_n, input, 1, reset, asynchronous, active-low.
REQ-012 The block SHALL have port I_en, input, 1, run request; timing starts or stops only at frame boundary.
REQ-013 The block SHALL have ports O_hs, O_vs and O_de, each output, 1: horizontal sync, vertical sync and data enable.
REQ-014 The block SHALL have ports O_x and O_y, each output, 11: active pixel column and row, valid when O_de=1.
REQ-015 The block SHALL have port O_frame_start, output, 1: one-cycle pulse on the first active pixel of each frame.
REQ-016 The block SHALL have ports O_r, O_g and O_b, each output, 8: test pattern colour.

Function
REQ-017 The block SHALL keep h_cnt counting 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1344 at default); wrap to 0 increments v_cnt.
REQ-018 The block SHALL keep v_cnt counting 0..V_TOTAL-1, where V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (806 at default); v_cnt wraps to 0 when h_cnt wraps at v_cnt=V_TOTAL-1.
REQ-019 The block SHALL have two states, IDLE and RUN; IDLE->RUN when I_en=1 in IDLE, and RUN->IDLE when I_en=0 at the last pixel of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1).
REQ-020 While in IDLE, the block SHALL hold the counters at 0, force O_de=0 and O_frame_start=0, and hold hs/vs at the inactive level.
REQ-021 Deasserting I_en mid-frame SHALL NOT truncate the frame; the frame completes.
REQ-022 The block SHALL assert de when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-023 The block SHALL make hs active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-024 The block SHALL make vs active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, with vs transitions aligned to h_cnt=0.
REQ-025 All outputs SHALL be registered, with exactly 1 cycle of latency from counter state; O_x=h_cnt and O_y=v_cnt when de=1, otherwise 0.
REQ-026 The block SHALL pulse O_frame_start for one cycle, coincident with O_de at x=0, y=0.
REQ-027 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-028 When I_rst_n=0, the block SHALL asynchronously enter IDLE, clear the counters, and drive O_de=0, O_frame_start=0, O_x=0, O_y=0, O_r/O_g/O_b=0, and O_hs/O_vs to the inactive level (~SYNC_POL).
REQ-029 On release of I_rst_n, the block SHALL remain in IDLE until I_en is sampled 1; the first O_de follows 2 cycles after that sample.

Configuration
REQ-030 With macro VTG_TEST_PATTERN_EN defined, the block SHALL drive O_r/O_g/O_b with 8 vertical colour bars of width H_ACTIVE/8 (128 px at default) in this order: white, yellow, cyan, green, magenta, red, blue, black; each channel is 8'hFF or 8'h00, with 0 when de=0; aligned with O_de.
REQ-031 Without VTG_TEST_PATTERN_EN, the ports SHALL remain present, O_r/O_g/O_b SHALL be tied 0, and no bar logic SHALL be synthesised.

Verification
REQ-032 Reset then I_en=1 -> first O_de and O_frame_start 2 cycles later, with O_x=0, O_y=0.
REQ-033 Free run at defaults -> O_de high 1024 cycles per line, O_hs low 136 cycles starting 1048 cycles after line start, line period 1344 cycles, frame period 1,083,264 cycles.
REQ-034 Free run -> O_vs low for exactly 6 lines starting at line 771, edges coincident with line start; 768 active lines per frame.
REQ-035 I_en=0 at y=400 -> frame completes to y=805, then the block enters IDLE with O_de=0 and hs/vs high; I_en=1 again -> new frame starts at x=0, y=0.
REQ-036 I_rst_n pulsed low mid-line at x=500 -> all outputs reach reset values within that cycle, with no glitch pulse on O_frame_start.
REQ-037 With VTG_TEST_PATTERN_EN, x=0 -> RGB FF/FF/FF; x=128 -> FF/FF/00; x=1023 -> 00/00/00; blanking -> 0. Without the macro, RGB=0 always.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with IDLE/RUN control and registered hs/vs/de/x/y.
// Define VTG_TEST_PATTERN_EN to drive 8 vertical colour bars on O_r/O_g/O_b.
module video_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int SYNC_POL = 0
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst_n,
    input  logic        I_en,
    output logic        O_hs,
    output logic        O_vs,
    output logic        O_de,
    output logic [10:0] O_x,
    output logic [10:0] O_y,
    output logic        O_frame_start,
    output logic [7:0]  O_r,
    output logic [7:0]  O_g,
    output logic [7:0]  O_b,
    output logic        O_state
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_last;
    logic        v_last;
    logic        de_c;
    logic        hs_c;
    logic        vs_c;

    // I_en is a level request: it is acted on only in IDLE or at the last pixel of a frame.
    assign h_last = (h_cnt == 11'(H_TOTAL - 1));
    assign v_last = (v_cnt == 11'(V_TOTAL - 1));
    assign de_c   = (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 11'(V_ACTIVE));
    assign hs_c   = (h_cnt >= 11'(H_ACTIVE + H_FP)) && (h_cnt < 11'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_c   = (v_cnt >= 11'(V_ACTIVE + V_FP)) && (v_cnt < 11'(V_ACTIVE + V_FP + V_SYNC));
    assign O_state = (state == RUN);

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state         <= IDLE;
            h_cnt         <= '0;
            v_cnt         <= '0;
            O_de          <= 1'b0;
            O_hs          <= ~SYNC_ACT;
            O_vs          <= ~SYNC_ACT;
            O_x           <= '0;
            O_y           <= '0;
            O_frame_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (I_en) state <= RUN;
                end
                RUN: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        if (v_last) begin
                            v_cnt <= '0;
                            if (!I_en) state <= IDLE;
                        end else begin
                            v_cnt <= v_cnt + 11'd1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 11'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Outputs reflect the counter state of the previous cycle.
            if (state == RUN) begin
                O_de          <= de_c;
                O_hs          <= hs_c ? SYNC_ACT : ~SYNC_ACT;
                O_vs          <= vs_c ? SYNC_ACT : ~SYNC_ACT;
                O_x           <= de_c ? h_cnt : 11'd0;
                O_y           <= de_c ? v_cnt : 11'd0;
                O_frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
            end else begin
                O_de          <= 1'b0;
                O_hs          <= ~SYNC_ACT;
                O_vs          <= ~SYNC_ACT;
                O_x           <= '0;
                O_y           <= '0;
                O_frame_start <= 1'b0;
            end
        end
    end

`ifdef VTG_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [10:0] bar_px;
    logic [2:0]  bar_idx;

    // Bar position tracks h_cnt without a divider; the index saturates past the last bar.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            bar_px  <= '0;
            bar_idx <= '0;
            O_r     <= '0;
            O_g     <= '0;
            O_b     <= '0;
        end else begin
            if (state != RUN || h_last) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == 11'(BAR_W - 1)) begin
                bar_px <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 11'd1;
            end

            // Bar order white..black maps to inverted index bits.
            if (state == RUN && de_c) begin
                O_r <= {8{~bar_idx[1]}};
                O_g <= {8{~bar_idx[2]}};
                O_b <= {8{~bar_idx[0]}};
            end else begin
                O_r <= '0;
                O_g <= '0;
                O_b <= '0;
            end
        end
    end
`else
    assign O_r = '0;
    assign O_g = '0;
    assign O_b = '0;
`endif

endmodule
